// File: rtl/image_write_if.sv
// Pixel-stream input and frame-memory write bus of the image_write frame sink.
interface image_write_if;
  // Pixel stream from the processing stage
  logic        VSYNC;
  logic        HSYNC;
  logic [7:0]  DATA_R0;
  logic [7:0]  DATA_G0;
  logic [7:0]  DATA_B0;
  logic [7:0]  DATA_R1;
  logic [7:0]  DATA_G1;
  logic [7:0]  DATA_B1;
  // Frame memory write port and frame status
  logic        wr_en;
  logic [20:0] wr_addr;
  logic [47:0] wr_data;
  logic        frame_done;
  logic        frame_err;
  logic [7:0]  frame_cnt;

  // Stream source / memory observer side
  modport master (
    output VSYNC, HSYNC, DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1,
    input  wr_en, wr_addr, wr_data, frame_done, frame_err, frame_cnt
  );

  // Frame sink side
  modport slave (
    input  VSYNC, HSYNC, DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1,
    output wr_en, wr_addr, wr_data, frame_done, frame_err, frame_cnt
  );
endinterface

// File: rtl/image_write.sv
// Frame sink: tracks row/col of an incoming two-pixel-per-clock stream and writes each pixel
// pair as one 48-bit word into a bottom-up BMP frame memory.
module image_write #(
  parameter int unsigned width_of_image   = 768,
  parameter int unsigned height_of_image  = 512,
  parameter int unsigned BMP_HEADER_BYTES = 54
) (
  input logic         HCLK,
  input logic         HRESET,
  image_write_if.slave bus
);

  localparam int unsigned ROW_STRIDE = ((width_of_image * 3 + 3) / 4) * 4;
  localparam int unsigned ColW       = $clog2(width_of_image);
  localparam int unsigned RowW       = $clog2(height_of_image);
  localparam logic [ColW-1:0] LastCol = ColW'(width_of_image - 2);
  localparam logic [RowW-1:0] LastRow = RowW'(height_of_image - 1);

  typedef enum logic [1:0] {StIdle, StWait, StActive, StDone} state_e;

  state_e          state_q, state_d;
  logic [RowW-1:0] row_q;
  logic [ColW-1:0] col_q;
  logic            wr_en_q;
  logic [20:0]     wr_addr_q;
  logic [47:0]     wr_data_q;
  logic            frame_err_q;
  logic [7:0]      frame_cnt_q;

  logic        vsync, hsync;
  logic        accept, restart, short_line, frame_done;
  logic        end_of_row, last_row;
  logic [20:0] addr_calc;

  assign vsync      = bus.VSYNC;
  assign hsync      = bus.HSYNC;
  assign end_of_row = (col_q == LastCol);
  assign last_row   = (row_q == LastRow);

  // Output row 0 is the top of the image, which lives in the last BMP row.
  assign addr_calc = 21'(BMP_HEADER_BYTES) + 21'(LastRow - row_q) * 21'(ROW_STRIDE)
                   + 21'(col_q) * 21'd3;

  // FSM state register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (vsync) state_d = StWait;
      end
      StWait: begin
        if (accept) state_d = StActive;
      end
      StActive: begin
        if (restart) begin
          state_d = StWait;
        end else if (accept && end_of_row && last_row) begin
          state_d = StDone;
        end else if (short_line && last_row) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: pair accept, frame restart, short-line detect and done pulse
  always_comb begin
    accept     = 1'b0;
    restart    = 1'b0;
    short_line = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      StWait: begin
        accept = hsync;
      end
      StActive: begin
        // VSYNC has priority: a pair arriving with it is dropped.
        restart    = vsync;
        accept     = hsync & ~vsync;
        short_line = ~vsync & ~hsync & (col_q != '0);
      end
      StDone: begin
        frame_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Position tracking, write pipeline and frame status
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      row_q       <= '0;
      col_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      wr_en_q <= accept;
      if (accept) begin
        wr_addr_q <= addr_calc;
        wr_data_q <= {bus.DATA_B1, bus.DATA_G1, bus.DATA_R1,
                      bus.DATA_B0, bus.DATA_G0, bus.DATA_R0};
      end

      if (state_q == StIdle && vsync) begin
        row_q       <= '0;
        col_q       <= '0;
        frame_err_q <= 1'b0;
      end else if (restart) begin
        row_q       <= '0;
        col_q       <= '0;
        frame_err_q <= 1'b1;
      end else if (accept) begin
        if (end_of_row) begin
          col_q <= '0;
          row_q <= row_q + RowW'(1);
        end else begin
          col_q <= col_q + ColW'(2);
        end
      end else if (short_line) begin
        // Missing pairs of a short line are simply skipped.
        frame_err_q <= 1'b1;
        col_q       <= '0;
        row_q       <= row_q + RowW'(1);
      end

      if (state_q != StDone && state_d == StDone) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.frame_done = frame_done;
  assign bus.frame_err  = frame_err_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_image_write.sv
// Self-checking bench for image_write with an 8x4 image.
module tb_image_write;

  localparam int W      = 8;
  localparam int H      = 4;
  localparam int HDR    = 54;
  localparam int STRIDE = 24;

  logic HCLK;
  logic HRESET;

  image_write_if bus ();

  image_write #(
    .width_of_image  (W),
    .height_of_image (H),
    .BMP_HEADER_BYTES(HDR)
  ) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [20:0] addr;
    logic [47:0] data;
  } wr_t;

  typedef struct {
    int l0, l1, l2, l3;
    int restart_after;
    int both_high;
    int exp_err;
    int exp_writes;
  } frame_vec_t;

  wr_t exp_q[$];
  int  n_checks   = 0;
  int  n_errors   = 0;
  int  wr_seen    = 0;
  int  done_seen  = 0;
  int  exp_cnt    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Byte address of pixel pair c (0-based pair index) on output row r.
  function automatic logic [20:0] pair_addr(input int r, input int c);
    return 21'(HDR + (H - 1 - r) * STRIDE + 3 * (2 * c));
  endfunction

  // Scoreboard: every write must match the oldest expected write.
  always @(negedge HCLK) begin
    if (bus.wr_en) begin
      wr_t e;
      wr_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'(bus.wr_addr), 64'h1_0000_0000);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
        chk("wr_data", 64'(bus.wr_data), 64'(e.data));
      end
    end
    if (bus.frame_done) done_seen++;
  end

  task automatic drive_pair(input logic [7:0] r0, g0, b0, r1, g1, b1,
                            input int r, input int c, input bit expect_it);
    wr_t e;
    bus.HSYNC   = 1'b1;
    bus.DATA_R0 = r0;
    bus.DATA_G0 = g0;
    bus.DATA_B0 = b0;
    bus.DATA_R1 = r1;
    bus.DATA_G1 = g1;
    bus.DATA_B1 = b1;
    if (expect_it) begin
      e.addr = pair_addr(r, c);
      e.data = {b1, g1, r1, b0, g0, r0};
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [7:0] rnd8();
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic vsync_pulse(input bit with_hsync, input bit check_clear);
    @(negedge HCLK);
    bus.VSYNC = 1'b1;
    if (with_hsync) drive_pair(rnd8(), rnd8(), rnd8(), rnd8(), rnd8(), rnd8(), 0, 0, 1'b0);
    else bus.HSYNC = 1'b0;
    @(negedge HCLK);
    bus.HSYNC = 1'b0;
    @(negedge HCLK);
    @(negedge HCLK);
    bus.VSYNC = 1'b0;
    if (check_clear) chk("err_cleared_by_vsync", 64'(bus.frame_err), 64'd0);
  endtask

  // Lines of l* pairs each followed by a 5-cycle gap; stops (HSYNC left high) after max_pairs.
  task automatic drive_lines(input int l0, l1, l2, l3, input int max_pairs);
    int lines[4];
    int total;
    lines[0] = l0;
    lines[1] = l1;
    lines[2] = l2;
    lines[3] = l3;
    total    = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < lines[r]; c++) begin
        if (total == max_pairs) return;
        @(negedge HCLK);
        drive_pair(rnd8(), rnd8(), rnd8(), rnd8(), rnd8(), rnd8(), r, c, 1'b1);
        total++;
      end
      @(negedge HCLK);
      bus.HSYNC = 1'b0;
      repeat (4) @(negedge HCLK);
    end
  endtask

  task automatic run_frame(input frame_vec_t v, input string tag);
    int w0;
    int d0;
    w0 = wr_seen;
    d0 = done_seen;
    vsync_pulse(1'b0, 1'b1);
    if (v.restart_after >= 0) begin
      drive_lines(4, 4, 4, 4, v.restart_after);
      vsync_pulse(v.both_high != 0, 1'b0);
    end
    drive_lines(v.l0, v.l1, v.l2, v.l3, 1000);
    repeat (3) @(negedge HCLK);
    exp_cnt = (exp_cnt + 1) % 256;
    chk({tag, "_done_pulses"}, 64'(done_seen - d0), 64'd1);
    chk({tag, "_writes"}, 64'(wr_seen - w0), 64'(v.exp_writes));
    chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_frame_err"}, 64'(bus.frame_err), 64'(v.exp_err));
    chk({tag, "_frame_cnt"}, 64'(bus.frame_cnt), 64'(exp_cnt));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr_en"}, 64'(bus.wr_en), 64'd0);
    chk({tag, "_wr_addr"}, 64'(bus.wr_addr), 64'd0);
    chk({tag, "_wr_data"}, 64'(bus.wr_data), 64'd0);
    chk({tag, "_frame_done"}, 64'(bus.frame_done), 64'd0);
    chk({tag, "_frame_err"}, 64'(bus.frame_err), 64'd0);
    chk({tag, "_frame_cnt"}, 64'(bus.frame_cnt), 64'd0);
  endtask

  // Async reset; with expect_wr the reset lands while a write is on the bus.
  task automatic pulse_reset(input bit expect_wr);
    if (expect_wr) begin
      @(posedge HCLK);
      #2;
      chk("wr_en_before_reset", 64'(bus.wr_en), 64'd1);
    end else begin
      @(negedge HCLK);
      #2;
    end
    bus.HSYNC = 1'b0;
    bus.VSYNC = 1'b0;
    HRESET    = 1'b1;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    exp_cnt = 0;
    @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  frame_vec_t vecs[6];
  frame_vec_t full;

  initial begin
    int w0;
    vecs[0] = '{4, 4, 4, 4, -1, 0, 0, 16};  // clean frame
    vecs[1] = '{4, 2, 4, 4, -1, 0, 1, 14};  // short line 1
    vecs[2] = '{4, 4, 4, 4,  6, 0, 1, 22};  // restart after 6 pairs
    vecs[3] = '{4, 4, 4, 4,  6, 1, 1, 22};  // restart with HSYNC+VSYNC together
    vecs[4] = '{4, 4, 4, 1, -1, 0, 1, 13};  // short last line ends frame
    vecs[5] = '{1, 3, 2, 4, -1, 0, 1, 10};  // several short lines
    full    = vecs[0];

    HRESET      = 1'b1;
    bus.VSYNC   = 1'b0;
    bus.HSYNC   = 1'b0;
    bus.DATA_R0 = '0;
    bus.DATA_G0 = '0;
    bus.DATA_B0 = '0;
    bus.DATA_R1 = '0;
    bus.DATA_G1 = '0;
    bus.DATA_B1 = '0;
    repeat (2) @(negedge HCLK);
    check_all_zero("reset");
    HRESET = 1'b0;
    @(negedge HCLK);

    // Byte order and one-cycle latency of the first pair
    vsync_pulse(1'b0, 1'b1);
    @(negedge HCLK);
    drive_pair(8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 0, 0, 1'b1);
    @(negedge HCLK);
    chk("order_wr_en", 64'(bus.wr_en), 64'd1);
    chk("order_wr_data", 64'(bus.wr_data), 64'h42_37_2C_21_16_0B);
    chk("order_wr_addr", 64'(bus.wr_addr), 64'd126);
    bus.HSYNC = 1'b0;
    pulse_reset(1'b0);

    // HSYNC without VSYNC is ignored
    w0 = wr_seen;
    for (int i = 0; i < 6; i++) begin
      @(negedge HCLK);
      drive_pair(rnd8(), rnd8(), rnd8(), rnd8(), rnd8(), rnd8(), 0, 0, 1'b0);
    end
    @(negedge HCLK);
    bus.HSYNC = 1'b0;
    repeat (3) @(negedge HCLK);
    chk("no_vsync_writes", 64'(wr_seen - w0), 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a line, then a clean frame from the top
    vsync_pulse(1'b0, 1'b1);
    drive_lines(4, 4, 4, 4, 5);
    pulse_reset(1'b1);
    repeat (2) @(negedge HCLK);
    run_frame(full, "after_reset");

    // 256 back-to-back frames wrap frame_cnt to zero
    pulse_reset(1'b0);
    w0 = wr_seen;
    for (int f = 0; f < 256; f++) begin
      run_frame(full, "b2b");
    end
    chk("wrap_frame_cnt", 64'(bus.frame_cnt), 64'd0);
    chk("wrap_total_writes", 64'(wr_seen - w0), 64'd4096);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", n_checks,
             n_errors);
    $fatal(1, "timeout");
  end

endmodule
